imem_boot_loader: RTL and testbench

- Upstream stage of Simple_Single_CPU.
- Receives a program as a byte stream over a valid/ready handshake and assembles it into 32-bit instruction words.
- Writes each word into instruction memory through a write port, holding the CPU in reset until loading completes.
- The program ends with an all-zero word. That word is also written to memory, because the zero word is how the CPU fetch marks end of program.

---
 rtl/imem_boot_loader.sv | 175 +++++++++++++++++
 tb/tb_imem_boot_loader.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a program as a byte stream (MSB first), packs it
// into 32-bit words and writes them to instruction memory. The CPU is held in
// reset until the all-zero terminator word has been written.
//
// Optional build macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, the terminator is followed by a 4-byte checksum (MSB first).
//   The checksum must equal the mod-2^32 sum of all written words, or the load
//   fails.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_i         asynchronous active-high reset
//   byte_valid_i  upstream byte valid
//   byte_data_i   upstream byte, MSB of each word first
//   byte_ready_o  loader accepts a byte this cycle
//   mem_we_o      one-cycle write strobe per word
//   mem_addr_o    word-aligned byte address of the write
//   mem_wdata_o   instruction word being written
//   cpu_rst_n_o   CPU reset, low while loading or after a failure
//   word_cnt_o    number of words written, terminator included
//   done_o        sticky load-success flag
//   err_o         sticky load-failure flag
module imem_boot_loader #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              cpu_rst_n_o,
    output logic [ADDR_W:0]   word_cnt_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    // Index of the last memory word; a non-terminator written here leaves no
    // room for the terminator.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << ADDR_W) - 1);

    typedef enum logic [2:0] {
        S_COLLECT,
        S_WRITE,
        S_DONE,
        S_ERROR
`ifdef IMEM_LOADER_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    state_t      state;
    logic [1:0]  byte_idx;
    logic [31:0] assembly;
    logic [31:0] next_word;
    logic        accept;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] sum;
`endif

    // Handshake uses the registered ready, so acceptance is known before the edge.
    assign accept    = byte_valid_i && byte_ready_o;
    assign next_word = {assembly[23:0], byte_data_i};

    // Loader FSM with registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= S_COLLECT;
            byte_idx     <= 2'd0;
            assembly     <= 32'd0;
            byte_ready_o <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= 32'd0;
            mem_wdata_o  <= 32'd0;
            cpu_rst_n_o  <= 1'b0;
            word_cnt_o   <= '0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum          <= 32'd0;
`endif
        end else begin
            // Write bus is idle except in the single WRITE cycle.
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'd0;
            mem_wdata_o <= 32'd0;

            case (state)
                S_COLLECT: begin
                    byte_ready_o <= 1'b1;
                    if (accept) begin
                        assembly <= next_word;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            state        <= S_WRITE;
                            byte_ready_o <= 1'b0;
                            mem_we_o     <= 1'b1;
                            mem_addr_o   <= 32'({word_cnt_o, 2'b00});
                            mem_wdata_o  <= next_word;
                        end
                    end
                end

                S_WRITE: begin
                    word_cnt_o <= word_cnt_o + CNT_W'(1);
                    byte_idx   <= 2'd0;
                    assembly   <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum        <= sum + assembly;
`endif
                    if (assembly == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state        <= S_CSUM;
                        byte_ready_o <= 1'b1;
`else
                        state        <= S_DONE;
                        done_o       <= 1'b1;
                        cpu_rst_n_o  <= 1'b1;
                        byte_ready_o <= 1'b0;
`endif
                    end else if (word_cnt_o == LAST_IDX) begin
                        state        <= S_ERROR;
                        err_o        <= 1'b1;
                        byte_ready_o <= 1'b0;
                    end else begin
                        state        <= S_COLLECT;
                        byte_ready_o <= 1'b1;
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                // Checksum bytes are assembled like a word but never written.
                S_CSUM: begin
                    byte_ready_o <= 1'b1;
                    if (accept) begin
                        assembly <= next_word;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            byte_ready_o <= 1'b0;
                            if (next_word == sum) begin
                                state       <= S_DONE;
                                done_o      <= 1'b1;
                                cpu_rst_n_o <= 1'b1;
                            end else begin
                                state <= S_ERROR;
                                err_o <= 1'b1;
                            end
                        end
                    end
                end
`endif

                S_DONE: begin
                    byte_ready_o <= 1'b0;
                end

                S_ERROR: begin
                    byte_ready_o <= 1'b0;
                end

                default: begin
                    state        <= S_ERROR;
                    err_o        <= 1'b1;
                    cpu_rst_n_o  <= 1'b0;
                    byte_ready_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: directed table vectors, hand-written reset and
// timing sequences, and random loads checked against a word-level model.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [7:0]  data = 8'd0;
    bit          sel = 1'b0;

    logic        rdy5, we5, crn5, done5, err5;
    logic [31:0] addr5, wdata5;
    logic [5:0]  cnt5;
    logic        rdy2, we2, crn2, done2, err2;
    logic [31:0] addr2, wdata2;
    logic [2:0]  cnt2;

    logic        rdy, we, crn, done, err;
    logic [31:0] addr, wdata, cnt;

    imem_boot_loader #(.ADDR_W(5)) dut5 (
        .clk_i(clk), .rst_i(rst), .byte_valid_i(valid), .byte_data_i(data),
        .byte_ready_o(rdy5), .mem_we_o(we5), .mem_addr_o(addr5), .mem_wdata_o(wdata5),
        .cpu_rst_n_o(crn5), .word_cnt_o(cnt5), .done_o(done5), .err_o(err5)
    );

    imem_boot_loader #(.ADDR_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .byte_valid_i(valid), .byte_data_i(data),
        .byte_ready_o(rdy2), .mem_we_o(we2), .mem_addr_o(addr2), .mem_wdata_o(wdata2),
        .cpu_rst_n_o(crn2), .word_cnt_o(cnt2), .done_o(done2), .err_o(err2)
    );

    always #5 clk = ~clk;

    // Outputs of the DUT under test (the other instance sees the same inputs).
    always_comb begin
        rdy   = sel ? rdy2   : rdy5;
        we    = sel ? we2    : we5;
        addr  = sel ? addr2  : addr5;
        wdata = sel ? wdata2 : wdata5;
        crn   = sel ? crn2   : crn5;
        done  = sel ? done2  : done5;
        err   = sel ? err2   : err5;
        cnt   = sel ? 32'(cnt2) : 32'(cnt5);
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Write monitor.
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (we) begin
                obs_addr.push_back(addr);
                obs_data.push_back(wdata);
                chk("ready_low_in_write", 32'(rdy), 32'd0);
            end else begin
                chk("bus_idle_zero", addr | wdata, 32'd0);
            end
        end
    end

    // Reference model: walks the stream a word at a time.
    logic [7:0]  stream[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    bit          exp_done, exp_err;
    int          consumed;

    task automatic model(input int depth);
        logic [31:0] w;
        logic [31:0] s;
        int i;
        exp_addr.delete();
        exp_data.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        consumed = 0;
        s = 32'd0;
        i = 0;
        while (!exp_done && !exp_err && consumed + 4 <= stream.size()) begin
            w = {stream[consumed], stream[consumed+1], stream[consumed+2], stream[consumed+3]};
            consumed += 4;
            exp_addr.push_back(32'(i * 4));
            exp_data.push_back(w);
            s += w;
            if (w == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (consumed + 4 <= stream.size()) begin
                    w = {stream[consumed], stream[consumed+1], stream[consumed+2], stream[consumed+3]};
                    consumed += 4;
                    if (w == s) exp_done = 1'b1;
                    else        exp_err  = 1'b1;
                end
                break;
`else
                exp_done = 1'b1;
`endif
            end else if (i == depth - 1) begin
                exp_err = 1'b1;
            end
            i++;
        end
    endtask

    // Reset both DUTs; async behaviour checked before any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        valid = 1'b0;
        data = 8'd0;
        #1;
        chk("rst_ready", 32'(rdy), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_cpu_rst_n", 32'(crn), 32'd0);
        chk("rst_cnt", cnt, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        obs_addr.delete();
        obs_data.delete();
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(rdy), 32'd1);
    endtask

    // Present one byte after 'gap' idle cycles; returns at the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit completes);
        int n;
        for (int g = 0; g < gap; g++) begin
            valid = 1'b0;
            @(negedge clk);
        end
        valid = 1'b1;
        data = b;
        n = 0;
        while (!rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rdy) begin
            chk("ready_timeout", 32'(rdy), 32'd1);
            valid = 1'b0;
            return;
        end
        @(negedge clk);
        if (completes) begin
            chk("we_after_4th_byte", 32'(we), 32'd1);
            chk("ready_low_after_4th", 32'(rdy), 32'd0);
        end
    endtask

    // Reset, feed the model-consumed part of 'stream', and compare the outcome.
    task automatic run_load(input bit s, input int gap, input bit rand_gap);
        bit fin;
        sel = s;
        do_reset();
        model(s ? 4 : 32);
        for (int k = 0; k < consumed; k++)
            send_byte(stream[k], rand_gap ? int'($urandom_range(0, 2)) : gap,
                      (k % 4 == 3) && (k < exp_addr.size() * 4));
        valid = 1'b0;
        repeat (3) @(negedge clk);
        fin = exp_done || exp_err;
        if (fin) begin
            // Bytes after completion must be ignored.
            for (int k = 0; k < 4; k++) begin
                valid = 1'b1;
                data = 8'($urandom);
                @(negedge clk);
            end
            valid = 1'b0;
            @(negedge clk);
        end
        chk("num_writes", 32'(obs_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            chk("write_addr", obs_addr[i], exp_addr[i]);
            chk("write_data", obs_data[i], exp_data[i]);
        end
        chk("done", 32'(done), 32'(exp_done));
        chk("err", 32'(err), 32'(exp_err));
        chk("cpu_rst_n", 32'(crn), 32'(exp_done));
        chk("word_cnt", cnt, 32'(exp_addr.size()));
        chk("ready_final", 32'(rdy), 32'(!fin));
    endtask

    typedef struct {
        string        name;
        bit           s;
        int           len;
        logic [127:0] bytes;
        int           gap;
        bit           e_done;
        bit           e_err;
        int           e_cnt;
        logic [31:0]  e_d0;
    } vec_t;

    function automatic vec_t mk(string n, bit s, int l, logic [127:0] b, int g,
                                bit d, bit e, int c, logic [31:0] d0);
        vec_t v;
        v.name = n; v.s = s; v.len = l; v.bytes = b; v.gap = g;
        v.e_done = d; v.e_err = e; v.e_cnt = c; v.e_d0 = d0;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        logic [127:0] tmp;
        logic [31:0]  w, s;
        int           nw;
        bit           term;

`ifdef IMEM_LOADER_CHECKSUM_EN
        tbl.push_back(mk("basic", 0, 12, {32'h20010005, 32'h0, 32'h20010005, 32'h0}, 0, 1, 0, 2, 32'h20010005));
        tbl.push_back(mk("gaps", 0, 12, {32'h20010005, 32'h0, 32'h20010005, 32'h0}, 3, 1, 0, 2, 32'h20010005));
        tbl.push_back(mk("overflow", 1, 16, {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444}, 0, 0, 1, 4, 32'h11111111));
        tbl.push_back(mk("stream", 0, 16, {32'hDEADBEEF, 32'h12345678, 32'h0, 32'hF0E21567}, 0, 1, 0, 3, 32'hDEADBEEF));
        tbl.push_back(mk("csum_ok", 0, 16, {32'h1, 32'h2, 32'h0, 32'h3}, 0, 1, 0, 3, 32'h1));
        tbl.push_back(mk("csum_bad", 0, 16, {32'h1, 32'h2, 32'h0, 32'h4}, 0, 0, 1, 3, 32'h1));
`else
        tbl.push_back(mk("basic", 0, 8, {32'h20010005, 32'h0, 64'h0}, 0, 1, 0, 2, 32'h20010005));
        tbl.push_back(mk("gaps", 0, 8, {32'h20010005, 32'h0, 64'h0}, 3, 1, 0, 2, 32'h20010005));
        tbl.push_back(mk("overflow", 1, 16, {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444}, 0, 0, 1, 4, 32'h11111111));
        tbl.push_back(mk("stream", 0, 12, {32'hDEADBEEF, 32'h12345678, 32'h0, 32'h0}, 0, 1, 0, 3, 32'hDEADBEEF));
`endif

        // Directed table.
        foreach (tbl[t]) begin
            stream.delete();
            tmp = tbl[t].bytes;
            for (int k = 0; k < tbl[t].len; k++)
                stream.push_back(tmp[127 - 8*k -: 8]);
            run_load(tbl[t].s, tbl[t].gap, 1'b0);
            chk({tbl[t].name, "/done"}, 32'(done), 32'(tbl[t].e_done));
            chk({tbl[t].name, "/err"}, 32'(err), 32'(tbl[t].e_err));
            chk({tbl[t].name, "/cnt"}, cnt, 32'(tbl[t].e_cnt));
            if (obs_data.size() > 0) chk({tbl[t].name, "/d0"}, obs_data[0], tbl[t].e_d0);
            else                     chk({tbl[t].name, "/has_write"}, 32'd0, 32'd1);
        end

        // Partial word then reset: nothing written, reload starts at address 0.
        sel = 1'b0;
        do_reset();
        send_byte(8'h20, 0, 1'b0);
        send_byte(8'h01, 0, 1'b0);
        valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("partial_no_write", 32'(obs_addr.size()), 32'd0);
        chk("partial_ready", 32'(rdy), 32'd1);
        stream.delete();
        tmp = {32'h8C000004, 32'h0, 64'h0};
        for (int k = 0; k < 8; k++) stream.push_back(tmp[127 - 8*k -: 8]);
`ifdef IMEM_LOADER_CHECKSUM_EN
        tmp = {32'h8C000004, 96'h0};
        for (int k = 0; k < 4; k++) stream.push_back(tmp[127 - 8*k -: 8]);
`endif
        run_load(1'b0, 0, 1'b0);
        if (obs_data.size() > 0) begin
            chk("reload_addr0", obs_addr[0], 32'd0);
            chk("reload_data0", obs_data[0], 32'h8C000004);
        end else begin
            chk("reload_has_write", 32'd0, 32'd1);
        end

        // Random loads on both memory depths.
        for (int r = 0; r < 24; r++) begin
            stream.delete();
            sel = 1'($urandom_range(0, 1));
            nw = int'($urandom_range(1, sel ? 5 : 7));
            s = 32'd0;
            term = 1'b0;
            for (int i = 0; i < nw; i++) begin
                w = $urandom;
                if (i == nw - 1 && $urandom_range(0, 3) != 0) begin
                    w = 32'd0;
                    term = 1'b1;
                end else if (w == 32'd0) begin
                    w = 32'd1;
                end
                s += w;
                for (int b = 3; b >= 0; b--) stream.push_back(w[8*b +: 8]);
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (term) begin
                w = ($urandom_range(0, 1) != 0) ? s : s + 32'd1;
                for (int b = 3; b >= 0; b--) stream.push_back(w[8*b +: 8]);
            end
`endif
            run_load(sel, 0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
